// File: rtl/multicycle_sequencer.sv
// Multicycle control FSM for the 5-instruction MIPS core on a single unified memory port.
// Sequences fetch/decode/execute/memory/writeback, stalls on mem_waitrequest, owns JR delay slot and halt.
module multicycle_sequencer #(
    parameter logic [5:0] HALT_OPCODE = 6'h3F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_waitrequest,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_addr_sel,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       target_write,
    output logic       alu_src,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       active,
    output logic       halt,
    output logic       error
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED
    } state_t;

    typedef enum logic [2:0] {
        C_ADDU, C_ADDIU, C_LW, C_SW, C_JR, C_HALT, C_ILL
    } cls_t;

    state_t state;
    cls_t   cls;
    cls_t   dec;
    logic   jump_pending;
    logic   ir_en;
    logic   pc_en;
    logic   mdr_en;

    // Instruction class from the IR fields; only consumed in DECODE.
    always_comb begin
        dec = C_ILL;
        if (opcode == 6'h00) begin
            if (funct == 6'h21)      dec = C_ADDU;
            else if (funct == 6'h08) dec = C_JR;
        end else if (opcode == 6'h23) begin
            dec = C_LW;
        end else if (opcode == 6'h2B) begin
            dec = C_SW;
        end else if (opcode == 6'h09) begin
            dec = C_ADDIU;
        end else if (opcode == HALT_OPCODE) begin
            dec = C_HALT;
        end
    end

    // Latch enables only take effect on the cycle the transfer completes.
    assign ir_write  = ir_en  & ~mem_waitrequest;
    assign pc_write  = pc_en  & ~mem_waitrequest;
    assign mdr_write = mdr_en & ~mem_waitrequest;

    // Each branch loads the Moore outputs belonging to the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cls          <= C_ILL;
            jump_pending <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_addr_sel <= 1'b0;
            ir_en        <= 1'b0;
            pc_en        <= 1'b0;
            mdr_en       <= 1'b0;
            pc_src       <= 1'b0;
            target_write <= 1'b0;
            alu_src      <= 1'b0;
            reg_dst      <= 1'b0;
            mem_to_reg   <= 1'b0;
            reg_write    <= 1'b0;
            active       <= 1'b0;
            halt         <= 1'b0;
            error        <= 1'b0;
        end else begin
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_addr_sel <= 1'b0;
            ir_en        <= 1'b0;
            pc_en        <= 1'b0;
            mdr_en       <= 1'b0;
            pc_src       <= 1'b0;
            target_write <= 1'b0;
            alu_src      <= 1'b0;
            reg_dst      <= 1'b0;
            mem_to_reg   <= 1'b0;
            reg_write    <= 1'b0;
            active       <= 1'b1;
            case (state)
                S_IDLE: begin
                    state    <= S_FETCH;
                    mem_read <= 1'b1;
                    ir_en    <= 1'b1;
                    pc_en    <= 1'b1;
                    pc_src   <= jump_pending;
                end
                S_FETCH: begin
                    if (mem_waitrequest) begin
                        mem_read <= 1'b1;
                        ir_en    <= 1'b1;
                        pc_en    <= 1'b1;
                        pc_src   <= pc_src;
                    end else begin
                        state        <= S_DECODE;
                        jump_pending <= 1'b0;
                    end
                end
                S_DECODE: begin
                    if (dec == C_HALT) begin
                        state  <= S_HALTED;
                        halt   <= 1'b1;
                        active <= 1'b0;
                    end else if (dec == C_ILL) begin
                        state  <= S_HALTED;
                        error  <= 1'b1;
                        active <= 1'b0;
                    end else begin
                        state        <= S_EXEC;
                        cls          <= dec;
                        alu_src      <= (dec == C_ADDIU) || (dec == C_LW) || (dec == C_SW);
                        target_write <= (dec == C_JR);
                    end
                end
                S_EXEC: begin
                    case (cls)
                        C_ADDU, C_ADDIU: begin
                            state     <= S_WB;
                            reg_write <= 1'b1;
                            reg_dst   <= (cls == C_ADDU);
                        end
                        C_LW, C_SW: begin
                            state        <= S_MEM;
                            mem_addr_sel <= 1'b1;
                            mem_read     <= (cls == C_LW);
                            mdr_en       <= (cls == C_LW);
                            mem_write    <= (cls == C_SW);
                        end
                        C_JR: begin
                            state        <= S_FETCH;
                            jump_pending <= 1'b1;
                            mem_read     <= 1'b1;
                            ir_en        <= 1'b1;
                            pc_en        <= 1'b1;
                            pc_src       <= 1'b1;
                        end
                        default: state <= S_IDLE;
                    endcase
                end
                S_MEM: begin
                    if (mem_waitrequest) begin
                        mem_addr_sel <= 1'b1;
                        mem_read     <= mem_read;
                        mem_write    <= mem_write;
                        mdr_en       <= mdr_en;
                    end else if (cls == C_LW) begin
                        state      <= S_WB;
                        reg_write  <= 1'b1;
                        mem_to_reg <= 1'b1;
                    end else begin
                        state    <= S_FETCH;
                        mem_read <= 1'b1;
                        ir_en    <= 1'b1;
                        pc_en    <= 1'b1;
                        pc_src   <= jump_pending;
                    end
                end
                S_WB: begin
                    state    <= S_FETCH;
                    mem_read <= 1'b1;
                    ir_en    <= 1'b1;
                    pc_en    <= 1'b1;
                    pc_src   <= jump_pending;
                end
                S_HALTED: active <= 1'b0;
                default:  state  <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: instruction table with per-cycle output checks
// and a writeback scoreboard, plus hand-written reset-during-stall sequences.
module tb_multicycle_sequencer;

    localparam logic [5:0] HALT_OP = 6'h3F;

    typedef enum int {K_ADDU, K_ADDIU, K_LW, K_SW, K_JR, K_HALT, K_ILL} kind_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         fw;
        int         mw;
        kind_t      kind;
        int         exp_cycles;
    } vec_t;

    typedef struct packed {
        logic rd;
        logic m2r;
    } wb_t;

    typedef struct packed {
        logic mem_read, mem_write, mem_addr_sel, ir_write, pc_write, mdr_write, pc_src;
        logic target_write, alu_src, reg_dst, mem_to_reg, reg_write, active, halt, error;
    } out_t;

    logic clk = 1'b0;
    logic reset;
    logic [5:0] opcode, funct;
    logic mem_waitrequest;
    logic mem_read, mem_write, mem_addr_sel, ir_write, mdr_write, pc_write, pc_src;
    logic target_write, alu_src, reg_dst, mem_to_reg, reg_write, active, halt, error;

    multicycle_sequencer dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .mem_waitrequest(mem_waitrequest),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr_sel(mem_addr_sel),
        .ir_write(ir_write), .mdr_write(mdr_write), .pc_write(pc_write), .pc_src(pc_src),
        .target_write(target_write), .alu_src(alu_src), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .active(active),
        .halt(halt), .error(error)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic pend = 1'b0;
    logic [5:0] cur_op, cur_fn;
    wb_t  sbq[$];
    vec_t tbl[$];

    function automatic out_t snap();
        out_t o;
        o.mem_read = mem_read;   o.mem_write = mem_write;     o.mem_addr_sel = mem_addr_sel;
        o.ir_write = ir_write;   o.pc_write = pc_write;       o.mdr_write = mdr_write;
        o.pc_src = pc_src;       o.target_write = target_write; o.alu_src = alu_src;
        o.reg_dst = reg_dst;     o.mem_to_reg = mem_to_reg;   o.reg_write = reg_write;
        o.active = active;       o.halt = halt;               o.error = error;
        return o;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, sample just after; pop the scoreboard on writeback.
    task automatic step(input logic w, input logic [5:0] op, input logic [5:0] fn, output out_t o);
        wb_t e;
        @(negedge clk);
        mem_waitrequest = w;
        opcode = op;
        funct = fn;
        #1;
        o = snap();
        cyc++;
        if (o.reg_write) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected at cycle %0d: got reg_write=1 want 0", cyc);
            end else begin
                e = sbq.pop_front();
                check("wb_select", 16'({o.reg_dst, o.mem_to_reg}), 16'({e.rd, e.m2r}));
            end
        end
    endtask

    task automatic async_reset();
        #1 reset = 1'b1;
        #1 check("reset_async", 16'(snap()), 16'h0);
        sbq.delete();
        pend = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1 check("idle_outputs", 16'(snap()), 16'h0);
    endtask

    task automatic do_fetch(input int fw);
        out_t o, e;
        for (int i = 0; i <= fw; i++) begin
            step(i < fw, HALT_OP, 6'($urandom), o);
            e = '0;
            e.mem_read = 1'b1;
            e.ir_write = !(i < fw);
            e.pc_write = !(i < fw);
            e.pc_src = pend;
            e.active = 1'b1;
            check("fetch", 16'(o), 16'(e));
        end
        pend = 1'b0;
    endtask

    task automatic do_decode(input logic [5:0] op, input logic [5:0] fn, input kind_t k);
        out_t o, e;
        cur_op = op;
        cur_fn = fn;
        if (k == K_ADDU || k == K_ADDIU || k == K_LW)
            sbq.push_back('{rd: (k == K_ADDU), m2r: (k == K_LW)});
        step(1'($urandom), op, fn, o);
        e = '0;
        e.active = 1'b1;
        check("decode", 16'(o), 16'(e));
    endtask

    task automatic do_exec(input kind_t k);
        out_t o, e;
        step(1'($urandom), cur_op, cur_fn, o);
        e = '0;
        e.active = 1'b1;
        e.alu_src = (k == K_ADDIU || k == K_LW || k == K_SW);
        e.target_write = (k == K_JR);
        check("exec", 16'(o), 16'(e));
        if (k == K_JR) pend = 1'b1;
    endtask

    function automatic out_t mem_exp(input kind_t k, input logic w);
        out_t e = '0;
        e.mem_addr_sel = 1'b1;
        e.mem_read = (k == K_LW);
        e.mem_write = (k == K_SW);
        e.mdr_write = (k == K_LW) && !w;
        e.active = 1'b1;
        return e;
    endfunction

    task automatic run_instr(input vec_t v);
        out_t o, e;
        int c0;
        c0 = cyc;
        do_fetch(v.fw);
        do_decode(v.op, v.fn, v.kind);
        if (v.kind == K_HALT || v.kind == K_ILL) begin
            check("halt_cycles", 16'(cyc - c0), 16'(v.exp_cycles));
            for (int i = 0; i < 20; i++) begin
                step(1'($urandom), 6'($urandom), 6'($urandom), o);
                e = '0;
                e.halt = (v.kind == K_HALT);
                e.error = (v.kind == K_ILL);
                check("halted", 16'(o), 16'(e));
            end
            @(negedge clk);
            async_reset();
            return;
        end
        do_exec(v.kind);
        if (v.kind == K_LW || v.kind == K_SW) begin
            for (int i = 0; i <= v.mw; i++) begin
                step(i < v.mw, cur_op, cur_fn, o);
                check("mem", 16'(o), 16'(mem_exp(v.kind, i < v.mw)));
            end
        end
        if (v.kind == K_ADDU || v.kind == K_ADDIU || v.kind == K_LW) begin
            step(1'($urandom), cur_op, cur_fn, o);
            e = '0;
            e.active = 1'b1;
            e.reg_write = 1'b1;
            e.reg_dst = (v.kind == K_ADDU);
            e.mem_to_reg = (v.kind == K_LW);
            check("wb", 16'(o), 16'(e));
        end
        check("instr_cycles", 16'(cyc - c0), 16'(v.exp_cycles));
    endtask

    initial begin
        out_t o;
        reset = 1'b1;
        mem_waitrequest = 1'b0;
        opcode = 6'h00;
        funct = 6'h00;

        //          op     fn     fw mw kind     cycles
        tbl.push_back('{6'h00, 6'h21, 0, 0, K_ADDU,  4});
        tbl.push_back('{6'h09, 6'h15, 0, 0, K_ADDIU, 4});
        tbl.push_back('{6'h23, 6'h00, 0, 3, K_LW,    8});
        tbl.push_back('{6'h2B, 6'h3F, 2, 0, K_SW,    6});
        tbl.push_back('{6'h23, 6'h08, 1, 1, K_LW,    7});
        tbl.push_back('{6'h00, 6'h08, 0, 0, K_JR,    3});
        tbl.push_back('{6'h09, 6'h00, 0, 0, K_ADDIU, 4});
        tbl.push_back('{6'h00, 6'h21, 0, 0, K_ADDU,  4});
        tbl.push_back('{6'h00, 6'h08, 0, 0, K_JR,    3});
        tbl.push_back('{6'h00, 6'h08, 1, 0, K_JR,    4});
        tbl.push_back('{6'h00, 6'h21, 1, 0, K_ADDU,  5});
        tbl.push_back('{6'h09, 6'h21, 0, 0, K_ADDIU, 4});
        tbl.push_back('{6'h2B, 6'h00, 0, 1, K_SW,    5});
        tbl.push_back('{6'h3F, 6'h00, 0, 0, K_HALT,  2});
        tbl.push_back('{6'h00, 6'h21, 0, 0, K_ADDU,  4});
        tbl.push_back('{6'h04, 6'h00, 0, 0, K_ILL,   2});
        tbl.push_back('{6'h00, 6'h20, 1, 0, K_ILL,   3});
        tbl.push_back('{6'h09, 6'h01, 0, 0, K_ADDIU, 4});

        @(negedge clk);
        async_reset();

        foreach (tbl[i]) run_instr(tbl[i]);

        // Reset during a delay-slot fetch stall must discard the pending jump.
        run_instr('{6'h00, 6'h08, 0, 0, K_JR, 3});
        step(1'b1, HALT_OP, 6'h00, o);
        check("pending_fetch_stall", 16'({o.mem_read, o.ir_write, o.pc_write, o.pc_src}), 16'(4'b1001));
        async_reset();
        run_instr('{6'h00, 6'h21, 0, 0, K_ADDU, 4});

        // Reset in the middle of an SW memory stall drops mem_write immediately.
        do_fetch(0);
        do_decode(6'h2B, 6'h00, K_SW);
        do_exec(K_SW);
        step(1'b1, cur_op, cur_fn, o);
        check("sw_stall", 16'(o), 16'(mem_exp(K_SW, 1'b1)));
        async_reset();
        run_instr('{6'h23, 6'h00, 0, 0, K_LW, 5});

        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending writebacks want 0", sbq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
